iter_div_unit: RTL and testbench

Parametrised, iterative radix-2 restoring divider for the RV64M execute stage, covering DIV, DIVU, REM, REMU and the word forms DIVW, DIVUW, REMW, REMUW. It sits beside the multiplier in EXU and takes one operation at a time over a valid/ready handshake. Divide-by-zero and signed overflow are resolved to RISC-V results on a fast path. A flush input aborts an in-flight operation.

---
 rtl/iter_div_unit_pkg.sv | 30 +++
 rtl/iter_div_unit_if.sv | 45 ++++
 rtl/iter_div_unit_div_operand_prep.sv | 43 ++++
 rtl/iter_div_unit.sv | 207 ++++++++++++++++++++
 tb/tb_iter_div_unit.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/iter_div_unit_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding,
// latched operation descriptor and the RV64M special-case result constants.
package iter_div_unit_pkg;

    // Controller states of the divider.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } div_state_t;

    // Operation flags captured at accept time.
    typedef struct packed {
        logic op_signed;
        logic op_rem;
        logic op_word;
    } div_op_t;

    // Native RV64 datapath width.
    localparam int unsigned RV_XLEN = 64;

    // Quotient returned for a zero divisor.
    localparam logic [RV_XLEN-1:0] RV_ALL_ONES = {RV_XLEN{1'b1}};

    // Most-negative value; dividing it by -1 overflows and yields itself.
    localparam logic [RV_XLEN-1:0] RV_MOST_NEG = {1'b1, {(RV_XLEN-1){1'b0}}};

endpackage

// File: rtl/iter_div_unit_if.sv
// Request/response bundle between the execute stage and the divider.
// The master side issues operations and consumes results; the slave is the unit.
interface iter_div_unit_if #(
    parameter int unsigned XLEN = 64
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            op_signed;
    logic            op_rem;
    logic            op_word;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    modport master (
        output flush,
        output in_valid,
        output dividend,
        output divisor,
        output op_signed,
        output op_rem,
        output op_word,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  result
    );

    modport slave (
        input  flush,
        input  in_valid,
        input  dividend,
        input  divisor,
        input  op_signed,
        input  op_rem,
        input  op_word,
        input  out_ready,
        output in_ready,
        output out_valid,
        output result
    );
endinterface

// File: rtl/iter_div_unit_div_operand_prep.sv
// Combinational operand conditioning: optional half-width (W-form) extension,
// absolute value and sign flags. Shared with the multiplier's MULH paths.
module div_operand_prep #(
    parameter int unsigned XLEN = 64
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            is_signed,
    input  logic            is_word,
    output logic [XLEN-1:0] ext_a,
    output logic [XLEN-1:0] ext_b,
    output logic [XLEN-1:0] abs_a,
    output logic [XLEN-1:0] abs_b,
    output logic            neg_a,
    output logic            neg_b
);
    localparam int unsigned HALF = XLEN / 2;

    // Low half passes through; the high half is replaced by the half-width
    // sign (or zero) in word mode so the rest of the unit sees an XLEN value.
    genvar gi;
    generate
        for (gi = 0; gi < XLEN; gi++) begin : g_ext
            if (gi < HALF) begin : g_low
                assign ext_a[gi] = a[gi];
                assign ext_b[gi] = b[gi];
            end else begin : g_high
                assign ext_a[gi] = is_word ? (is_signed & a[HALF-1]) : a[gi];
                assign ext_b[gi] = is_word ? (is_signed & b[HALF-1]) : b[gi];
            end
        end
    endgenerate

    // Sign flags only matter for signed operations.
    assign neg_a = is_signed & ext_a[XLEN-1];
    assign neg_b = is_signed & ext_b[XLEN-1];

    // Magnitudes; the most-negative value maps onto itself, which the
    // unsigned iteration still treats correctly as 2^(XLEN-1).
    assign abs_a = neg_a ? (-ext_a) : ext_a;
    assign abs_b = neg_b ? (-ext_b) : ext_b;

endmodule

// File: rtl/iter_div_unit.sv
// Iterative radix-2 restoring divider for RV64M DIV/REM and their W forms.
// One operation at a time; zero divisor and signed overflow bypass the loop.
module iter_div_unit
    import iter_div_unit_pkg::*;
#(
    parameter int unsigned XLEN = RV_XLEN
) (
    input  logic             clk,
    input  logic             rst,
    iter_div_unit_if.slave   bus
);
    localparam int unsigned HALF = XLEN / 2;
    // Counter must hold the value XLEN without wrapping.
    localparam int unsigned CW   = $clog2(XLEN) + 1;

    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    // Sign-extended most-negative half-width value, as seen after extension.
    localparam logic [XLEN-1:0] WORD_MOST_NEG = ALL_ONES << (HALF - 1);

    div_state_t      state_reg, state_next;

    logic [XLEN-1:0] a_reg, b_reg;
    div_op_t         op_reg;
    logic [XLEN-1:0] rem_reg, quo_reg, dvs_reg;
    logic            q_neg_reg, r_neg_reg;
    logic [CW-1:0]   cnt_reg;
    logic [XLEN-1:0] result_reg;

    logic [XLEN-1:0] ext_a, ext_b, abs_a, abs_b;
    logic            neg_a, neg_b;

    logic            div_zero, sgn_ovf, special;
    logic [XLEN-1:0] special_res;
    logic [CW-1:0]   n_last;
    logic [XLEN:0]   shifted;
    logic            trial_ge;
    logic [XLEN-1:0] rem_step, quo_step;
    logic [XLEN-1:0] q_fix, r_fix, fix_res;
    logic            accept;

    // Select quotient or remainder and apply the RV64 word sign-extension,
    // which also applies to unsigned word forms.
    function automatic logic [XLEN-1:0] pick_result(
        input logic [XLEN-1:0] q,
        input logic [XLEN-1:0] r,
        input div_op_t         op
    );
        logic [XLEN-1:0] sel;
        sel = op.op_rem ? r : q;
        if (op.op_word) begin
            sel = {{HALF{sel[HALF-1]}}, sel[HALF-1:0]};
        end
        return sel;
    endfunction

    div_operand_prep #(
        .XLEN (XLEN)
    ) u_prep (
        .a         (a_reg),
        .b         (b_reg),
        .is_signed (op_reg.op_signed),
        .is_word   (op_reg.op_word),
        .ext_a     (ext_a),
        .ext_b     (ext_b),
        .abs_a     (abs_a),
        .abs_b     (abs_b),
        .neg_a     (neg_a),
        .neg_b     (neg_b)
    );

    assign bus.in_ready  = (state_reg == ST_IDLE);
    assign bus.out_valid = (state_reg == ST_DONE);
    assign bus.result    = result_reg;

    assign accept = bus.in_valid && !bus.flush;

    // Special cases are judged on the extended operands, so W forms get
    // 32-bit semantics automatically.
    assign div_zero    = (ext_b == '0);
    assign sgn_ovf     = op_reg.op_signed && (ext_b == ALL_ONES) &&
                         (ext_a == (op_reg.op_word ? WORD_MOST_NEG : MOST_NEG));
    assign special     = div_zero || sgn_ovf;
    assign special_res = pick_result(div_zero ? ALL_ONES : ext_a,
                                     div_zero ? ext_a : '0, op_reg);

    // Index of the final iteration for the current width.
    assign n_last = op_reg.op_word ? CW'(HALF - 1) : CW'(XLEN - 1);

    // One restoring step: shift {rem, quo} left, trial-subtract the divisor
    // magnitude and keep the difference only when it does not go negative.
    assign shifted  = {rem_reg, quo_reg[XLEN-1]};
    assign trial_ge = (shifted >= {1'b0, dvs_reg});
    assign rem_step = trial_ge ? XLEN'(shifted - {1'b0, dvs_reg}) : shifted[XLEN-1:0];
    assign quo_step = {quo_reg[XLEN-2:0], trial_ge};

    // Sign fix-up: quotient sign is the XOR of operand signs, remainder
    // follows the dividend.
    assign q_fix   = q_neg_reg ? (-quo_reg) : quo_reg;
    assign r_fix   = r_neg_reg ? (-rem_reg) : rem_reg;
    assign fix_res = pick_result(q_fix, r_fix, op_reg);

    // Next-state logic; flush overrides every other request.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_PREP;
                end
            end
            ST_PREP: begin
                if (bus.flush) begin
                    state_next = ST_IDLE;
                end else if (special) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_CALC;
                end
            end
            ST_CALC: begin
                if (bus.flush) begin
                    state_next = ST_IDLE;
                end else if (cnt_reg == n_last) begin
                    state_next = ST_FIX;
                end
            end
            ST_FIX: begin
                state_next = bus.flush ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                if (bus.flush || bus.out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Operand capture, iteration registers and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg      <= '0;
            b_reg      <= '0;
            op_reg     <= '0;
            rem_reg    <= '0;
            quo_reg    <= '0;
            dvs_reg    <= '0;
            q_neg_reg  <= 1'b0;
            r_neg_reg  <= 1'b0;
            cnt_reg    <= '0;
            result_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        a_reg            <= bus.dividend;
                        b_reg            <= bus.divisor;
                        op_reg.op_signed <= bus.op_signed;
                        op_reg.op_rem    <= bus.op_rem;
                        op_reg.op_word   <= bus.op_word;
                    end
                end
                ST_PREP: begin
                    if (!bus.flush) begin
                        if (special) begin
                            result_reg <= special_res;
                        end else begin
                            rem_reg   <= '0;
                            // W forms park the magnitude in the upper half so
                            // HALF shifts consume exactly its significant bits.
                            quo_reg   <= op_reg.op_word ? (abs_a << HALF) : abs_a;
                            dvs_reg   <= abs_b;
                            q_neg_reg <= neg_a ^ neg_b;
                            r_neg_reg <= neg_a;
                            cnt_reg   <= '0;
                        end
                    end
                end
                ST_CALC: begin
                    if (!bus.flush) begin
                        rem_reg <= rem_step;
                        quo_reg <= quo_step;
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                ST_FIX: begin
                    if (!bus.flush) begin
                        result_reg <= fix_res;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_div_unit.sv
// Self-checking bench for iter_div_unit: directed RV64M cases, flush/reset
// behaviour, result hold under back-pressure and randomized operations
// compared against an arithmetic reference model.
module tb_iter_div_unit;
    import iter_div_unit_pkg::*;

    localparam int unsigned XLEN = 64;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    iter_div_unit_if #(.XLEN(XLEN)) bus ();

    iter_div_unit #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Single comparison point for the whole bench.
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model straight from the RISC-V M-extension rules.
    function automatic logic [63:0] ref_div(input logic [63:0] a, input logic [63:0] b,
                                            input bit s, input bit r, input bit w);
        logic [63:0] q, rm, res, ua, ub;
        longint      sa, sb;
        if (w) begin
            if (s) begin
                sa = longint'($signed(a[31:0]));
                sb = longint'($signed(b[31:0]));
                if (sb == 0) begin
                    q  = '1;
                    rm = sa;
                end else begin
                    q  = sa / sb;
                    rm = sa % sb;
                end
            end else begin
                ua = {32'h0, a[31:0]};
                ub = {32'h0, b[31:0]};
                if (ub == 0) begin
                    q  = '1;
                    rm = ua;
                end else begin
                    q  = ua / ub;
                    rm = ua % ub;
                end
            end
            res = r ? rm : q;
            res = {{32{res[31]}}, res[31:0]};
        end else begin
            if (b == 0) begin
                q  = '1;
                rm = a;
            end else if (s && a == RV_MOST_NEG && b == RV_ALL_ONES) begin
                q  = a;
                rm = '0;
            end else if (s) begin
                q  = $signed(a) / $signed(b);
                rm = $signed(a) % $signed(b);
            end else begin
                q  = a / b;
                rm = a % b;
            end
            res = r ? rm : q;
        end
        return res;
    endfunction

    // Expected edges from accept (inclusive) to first out_valid cycle.
    function automatic int ref_lat(input logic [63:0] a, input logic [63:0] b,
                                   input bit s, input bit w);
        bit zero, ovf;
        zero = w ? (b[31:0] == 32'h0) : (b == 64'h0);
        ovf  = s && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                       : (a == RV_MOST_NEG && b == RV_ALL_ONES));
        if (zero || ovf) return 2;
        return w ? 35 : 67;
    endfunction

    task automatic start_op(input logic [63:0] a, input logic [63:0] b,
                            input bit s, input bit r, input bit w);
        bus.dividend  = a;
        bus.divisor   = b;
        bus.op_signed = s;
        bus.op_rem    = r;
        bus.op_word   = w;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        bus.dividend  = '1;
        bus.divisor   = '1;
    endtask

    // Full transaction with latency, result and hold checks.
    task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input bit s, input bit r, input bit w,
                         input logic [63:0] exp_res, input int exp_lat, input int hold);
        int lat;
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        start_op(a, b, s, r, w);
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            tick();
            lat++;
        end
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_res"}, bus.result, exp_res);
        $display("txn %s a=%h b=%h s=%0d r=%0d w=%0d res=%h lat=%0d",
                 tag, a, b, s, r, w, bus.result, lat);
        for (int k = 0; k < hold; k++) begin
            tick();
            chk({tag, "_hold_res"}, bus.result, exp_res);
            chk({tag, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
            chk({tag, "_hold_in_ready"}, 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, "_drop_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_idle"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.op_signed = 1'b0;
        bus.op_rem    = 1'b0;
        bus.op_word   = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_result", bus.result, 64'd0);

        // Directed RV64M cases.
        do_op("divu",   64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 64'd14, 67, 0);
        do_op("remu",   64'd100, 64'd7, 1'b0, 1'b1, 1'b0, 64'd2, 67, 0);
        do_op("div_neg", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, 1'b0,
              64'hFFFF_FFFF_FFFF_FFFD, 67, 0);
        do_op("rem_neg", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b1, 1'b0,
              64'hFFFF_FFFF_FFFF_FFFF, 67, 0);
        do_op("div_z",  64'd5, 64'd0, 1'b1, 1'b0, 1'b0, RV_ALL_ONES, 2, 0);
        do_op("rem_z",  64'd5, 64'd0, 1'b1, 1'b1, 1'b0, 64'd5, 2, 0);
        do_op("div_ovf", RV_MOST_NEG, RV_ALL_ONES, 1'b1, 1'b0, 1'b0, RV_MOST_NEG, 2, 0);
        do_op("rem_ovf", RV_MOST_NEG, RV_ALL_ONES, 1'b1, 1'b1, 1'b0, 64'd0, 2, 0);
        do_op("divuw",  64'h0000_0001_FFFF_FFFE, 64'd1, 1'b0, 1'b0, 1'b1,
              64'hFFFF_FFFF_FFFF_FFFE, 35, 0);
        do_op("divw_ovf", 64'h0000_0000_8000_0000, RV_ALL_ONES, 1'b1, 1'b0, 1'b1,
              64'hFFFF_FFFF_8000_0000, 2, 0);
        do_op("divw",   64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002, 1'b1, 1'b0, 1'b1,
              64'hFFFF_FFFF_FFFF_FFFD, 35, 0);
        do_op("remuw_z", 64'h1111_1111_8000_0005, 64'h2222_2222_0000_0000, 1'b0, 1'b1, 1'b1,
              64'hFFFF_FFFF_8000_0005, 2, 0);

        // Flush in IDLE beats in_valid: nothing is accepted.
        bus.flush = 1'b1;
        start_op(64'd9, 64'd3, 1'b0, 1'b0, 1'b0);
        bus.flush = 1'b0;
        chk("flush_idle_ready", 64'(bus.in_ready), 64'd1);

        // Flush after 10 iterations: no result ever appears.
        start_op(64'd1000, 64'd3, 1'b0, 1'b0, 1'b0);
        tick();
        repeat (10) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush_calc_ready", 64'(bus.in_ready), 64'd1);
        chk("flush_calc_valid", 64'(bus.out_valid), 64'd0);
        seen = 0;
        for (int k = 0; k < 80; k++) begin
            tick();
            if (bus.out_valid) seen++;
        end
        chk("flush_calc_quiet", 64'(seen), 64'd0);
        do_op("post_flush", 64'd12, 64'd4, 1'b0, 1'b0, 1'b0, 64'd3, 67, 0);

        // Flush while the result is waiting.
        start_op(64'd50, 64'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("flush_done_valid", 64'(bus.out_valid), 64'd1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush_done_drop", 64'(bus.out_valid), 64'd0);
        chk("flush_done_ready", 64'(bus.in_ready), 64'd1);

        // Back-pressure: result held for 5 cycles.
        do_op("hold", 64'd1000, 64'd7, 1'b0, 1'b0, 1'b0, 64'd142, 67, 5);

        // Randomized operations against the reference model.
        for (int i = 0; i < 60; i++) begin
            logic [63:0] a, b;
            bit          s, r, w;
            int          kind;
            s    = 1'($urandom_range(0, 1));
            r    = 1'($urandom_range(0, 1));
            w    = 1'($urandom_range(0, 1));
            a    = {32'($urandom()), 32'($urandom())};
            b    = {32'($urandom()), 32'($urandom())};
            kind = int'($urandom_range(0, 9));
            case (kind)
                0: b = w ? {32'($urandom()), 32'h0} : 64'h0;
                1: begin
                    s = 1'b1;
                    a = w ? {32'($urandom()), 32'h8000_0000} : RV_MOST_NEG;
                    b = w ? {32'($urandom()), 32'hFFFF_FFFF} : RV_ALL_ONES;
                end
                2: begin
                    b = 64'($urandom_range(1, 15));
                    if ($urandom_range(0, 1) == 1) b = -b;
                end
                3: a = 64'($urandom_range(0, 100));
                default: begin
                end
            endcase
            do_op($sformatf("rnd%0d", i), a, b, s, r, w,
                  ref_div(a, b, s, r, w), ref_lat(a, b, s, w),
                  int'($urandom_range(0, 3)));
        end

        // Reset in the middle of an iteration run.
        start_op(64'd123456789, 64'd77, 1'b1, 1'b0, 1'b0);
        repeat (20) tick();
        rst = 1'b1;
        tick();
        chk("rst_mid_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_mid_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_mid_result", bus.result, 64'd0);
        rst = 1'b0;
        do_op("post_rst", 64'd12, 64'd4, 1'b0, 1'b1, 1'b0, 64'd0, 67, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
